// File: rtl/m_store_narrow.sv
// Memory-stage store unit: narrows register data to the store width, checks
// for address errors and issues the store to data memory via a one-entry buffer.
module m_store_narrow #(
   parameter logic [31:0] ADDR_LO = 32'h0000_0000,
   parameter logic [31:0] ADDR_HI = 32'h0000_2FFF
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        store_valid,
   input  logic [1:0]  store_op,
   input  logic [31:0] store_addr,
   input  logic [31:0] store_wdata,
   input  logic        flush,
   output logic        stall,
   output logic        exc_ades,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_byteen,
   input  logic        mem_ack,
   output logic [15:0] store_cnt
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [1:0] OP_SW = 2'b00;
   localparam logic [1:0] OP_SH = 2'b01;
   localparam logic [1:0] OP_SB = 2'b10;
   localparam logic [1:0] OP_RS = 2'b11;

   state_t      state, next_state;
   logic        misaligned;
   logic        out_of_range;
   logic        legal;
   logic        load;
   logic [31:0] narrow_wdata;
   logic [3:0]  narrow_byteen;

   // Reserved op is silently ignored, so it can never raise an address error.
   always_comb begin
      misaligned   = ((store_op == OP_SH) && store_addr[0]) ||
                     ((store_op == OP_SW) && (store_addr[1:0] != 2'b00));
      out_of_range = (store_addr < ADDR_LO) || (store_addr > ADDR_HI);
      exc_ades     = store_valid && !flush && (store_op != OP_RS) &&
                     (misaligned || out_of_range);
      legal        = store_valid && (store_op != OP_RS) && !flush && !exc_ades;
   end

   always_comb begin
      narrow_wdata  = store_wdata;
      narrow_byteen = 4'b1111;
      case (store_op)
         OP_SB: begin
            narrow_wdata  = {4{store_wdata[7:0]}};
            narrow_byteen = 4'b0001 << store_addr[1:0];
         end
         OP_SH: begin
            narrow_wdata  = {2{store_wdata[15:0]}};
            narrow_byteen = store_addr[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            narrow_wdata  = store_wdata;
            narrow_byteen = 4'b1111;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (legal) next_state = BUSY;
         BUSY:    if (mem_ack && !legal) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // The buffer refills either from empty or on the edge its current entry retires.
   always_comb begin
      mem_req = (state == BUSY);
      stall   = (state == BUSY) && !mem_ack && legal;
      load    = legal && ((state == IDLE) || mem_ack);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mem_addr   <= 32'h0;
         mem_wdata  <= 32'h0;
         mem_byteen <= 4'h0;
      end else if (load) begin
         mem_addr   <= {store_addr[31:2], 2'b00};
         mem_wdata  <= narrow_wdata;
         mem_byteen <= narrow_byteen;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                             store_cnt <= 16'h0;
      else if ((state == BUSY) && mem_ack)     store_cnt <= store_cnt + 16'd1;
   end

endmodule

// File: tb/tb_m_store_narrow.sv
// Directed bench for m_store_narrow: a queue scoreboard tracks every issued
// store and a monitor retires entries as memory acknowledges them.
`timescale 1ns/1ps
module tb_m_store_narrow;

   logic        clk = 1'b0;
   logic        resetn;
   logic        store_valid;
   logic [1:0]  store_op;
   logic [31:0] store_addr;
   logic [31:0] store_wdata;
   logic        flush;
   logic        stall;
   logic        exc_ades;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_byteen;
   logic        mem_ack;
   logic [15:0] store_cnt;

   int vectors = 0;
   int miscompares = 0;
   logic [67:0] sb_q[$];

   m_store_narrow dut (
      .clk(clk), .resetn(resetn), .store_valid(store_valid), .store_op(store_op),
      .store_addr(store_addr), .store_wdata(store_wdata), .flush(flush),
      .stall(stall), .exc_ades(exc_ades), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_byteen(mem_byteen), .mem_ack(mem_ack),
      .store_cnt(store_cnt)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Reference legality and narrowing, written from the store-width rules.
   function automatic logic model_fault(input logic [1:0] op, input logic [31:0] a);
      logic bad;
      bad = (a > 32'h0000_2FFF);
      if (op == 2'b00 && a[1:0] != 2'b00) bad = 1'b1;
      if (op == 2'b01 && a[0]) bad = 1'b1;
      return bad;
   endfunction

   function automatic logic [67:0] model_pkt(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] d);
      logic [31:0] w;
      logic [3:0]  be;
      if (op == 2'b10) begin
         w = {d[7:0], d[7:0], d[7:0], d[7:0]};
         case (a[1:0])
            2'd0: be = 4'b0001;
            2'd1: be = 4'b0010;
            2'd2: be = 4'b0100;
            default: be = 4'b1000;
         endcase
      end else if (op == 2'b01) begin
         w  = {d[15:0], d[15:0]};
         be = a[1] ? 4'b1100 : 4'b0011;
      end else begin
         w  = d;
         be = 4'b1111;
      end
      return {a[31:2], 2'b00, w, be};
   endfunction

   task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] d, input logic fl);
      store_valid = v;
      store_op    = op;
      store_addr  = a;
      store_wdata = d;
      flush       = fl;
      if (v && !fl && op != 2'b11 && !model_fault(op, a)) sb_q.push_back(model_pkt(op, a, d));
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Retire one scoreboard entry on every cycle that will complete a store.
   always @(negedge clk) begin
      if (resetn && mem_req && mem_ack) begin
         logic [67:0] exp_pkt;
         if (sb_q.size() == 0) begin
            checkOutput("sb_underflow", 32'd0, 32'd1);
         end else begin
            exp_pkt = sb_q.pop_front();
            checkOutput("sb_addr", mem_addr, exp_pkt[67:36]);
            checkOutput("sb_wdata", mem_wdata, exp_pkt[35:4]);
            checkOutput("sb_byteen", {28'h0, mem_byteen}, {28'h0, exp_pkt[3:0]});
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      resetn  = 1'b0;
      mem_ack = 1'b0;
      applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
      #2;
      checkOutput("rst_req", {31'h0, mem_req}, 32'h0);
      checkOutput("rst_addr", mem_addr, 32'h0);
      checkOutput("rst_wdata", mem_wdata, 32'h0);
      checkOutput("rst_byteen", {28'h0, mem_byteen}, 32'h0);
      checkOutput("rst_cnt", {16'h0, store_cnt}, 32'h0);
      @(negedge clk);
      resetn = 1'b1;
      tick();

      // Width sweep with memory always ready.
      mem_ack = 1'b1;
      applyStimulus(1'b1, 2'b10, 32'h0000_1003, 32'h1234_5678, 1'b0);
      checkOutput("sb_stall", {31'h0, stall}, 32'h0);
      tick();
      checkOutput("sb_req", {31'h0, mem_req}, 32'h1);
      checkOutput("sb_maddr", mem_addr, 32'h0000_1000);
      checkOutput("sb_mwdata", mem_wdata, 32'h7878_7878);
      checkOutput("sb_mbe", {28'h0, mem_byteen}, 32'h8);
      applyStimulus(1'b1, 2'b01, 32'h0000_1002, 32'h1234_5678, 1'b0);
      tick();
      checkOutput("sh_mwdata", mem_wdata, 32'h5678_5678);
      checkOutput("sh_mbe", {28'h0, mem_byteen}, 32'hC);
      checkOutput("sh_cnt", {16'h0, store_cnt}, 32'd1);
      applyStimulus(1'b1, 2'b00, 32'h0000_1000, 32'h1234_5678, 1'b0);
      tick();
      checkOutput("sw_mwdata", mem_wdata, 32'h1234_5678);
      checkOutput("sw_mbe", {28'h0, mem_byteen}, 32'hF);
      checkOutput("sw_req", {31'h0, mem_req}, 32'h1);
      applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
      tick();
      checkOutput("sweep_req", {31'h0, mem_req}, 32'h0);
      checkOutput("sweep_cnt", {16'h0, store_cnt}, 32'd3);

      // Address errors.
      applyStimulus(1'b1, 2'b00, 32'h0000_1002, 32'hDEAD_BEEF, 1'b0);
      checkOutput("ades_sw", {31'h0, exc_ades}, 32'h1);
      checkOutput("ades_sw_stall", {31'h0, stall}, 32'h0);
      tick();
      checkOutput("ades_sw_req", {31'h0, mem_req}, 32'h0);
      applyStimulus(1'b1, 2'b01, 32'h0000_0001, 32'hDEAD_BEEF, 1'b0);
      checkOutput("ades_sh", {31'h0, exc_ades}, 32'h1);
      tick();
      checkOutput("ades_sh_req", {31'h0, mem_req}, 32'h0);
      applyStimulus(1'b1, 2'b10, 32'h0000_3000, 32'hDEAD_BEEF, 1'b0);
      checkOutput("ades_sb", {31'h0, exc_ades}, 32'h1);
      tick();
      checkOutput("ades_sb_req", {31'h0, mem_req}, 32'h0);
      applyStimulus(1'b1, 2'b10, 32'h0000_2FFF, 32'h0000_0011, 1'b0);
      checkOutput("edge_hi_ok", {31'h0, exc_ades}, 32'h0);
      tick();
      applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
      tick();
      checkOutput("edge_hi_cnt", {16'h0, store_cnt}, 32'd4);

      // Slow memory: A held while B stalls.
      mem_ack = 1'b0;
      applyStimulus(1'b1, 2'b00, 32'h0000_0100, 32'hAAAA_5555, 1'b0);
      tick();
      applyStimulus(1'b1, 2'b10, 32'h0000_0205, 32'h0000_00CD, 1'b0);
      for (int i = 0; i < 3; i++) begin
         checkOutput("slow_stall", {31'h0, stall}, 32'h1);
         checkOutput("slow_addr", mem_addr, 32'h0000_0100);
         checkOutput("slow_wdata", mem_wdata, 32'hAAAA_5555);
         tick();
      end
      mem_ack = 1'b1;
      #1;
      checkOutput("slow_ack_stall", {31'h0, stall}, 32'h0);
      tick();
      checkOutput("slow_b_req", {31'h0, mem_req}, 32'h1);
      checkOutput("slow_b_wdata", mem_wdata, 32'hCDCD_CDCD);
      checkOutput("slow_b_be", {28'h0, mem_byteen}, 32'h2);
      checkOutput("slow_cnt", {16'h0, store_cnt}, 32'd5);
      applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
      tick();
      checkOutput("slow_done_cnt", {16'h0, store_cnt}, 32'd6);

      // Flushed and reserved ops are dropped silently.
      applyStimulus(1'b1, 2'b00, 32'h0000_0400, 32'h1111_1111, 1'b1);
      checkOutput("flush_exc", {31'h0, exc_ades}, 32'h0);
      checkOutput("flush_stall", {31'h0, stall}, 32'h0);
      tick();
      checkOutput("flush_req", {31'h0, mem_req}, 32'h0);
      applyStimulus(1'b1, 2'b11, 32'h0000_3001, 32'h2222_2222, 1'b0);
      checkOutput("rsvd_exc", {31'h0, exc_ades}, 32'h0);
      tick();
      checkOutput("rsvd_req", {31'h0, mem_req}, 32'h0);

      // Flush during BUSY keeps the buffered store.
      mem_ack = 1'b0;
      applyStimulus(1'b1, 2'b00, 32'h0000_0800, 32'h3333_3333, 1'b0);
      tick();
      applyStimulus(1'b1, 2'b00, 32'h0000_0900, 32'h4444_4444, 1'b1);
      checkOutput("busy_flush_stall", {31'h0, stall}, 32'h0);
      tick();
      checkOutput("busy_flush_req", {31'h0, mem_req}, 32'h1);
      checkOutput("busy_flush_addr", mem_addr, 32'h0000_0800);
      applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
      mem_ack = 1'b1;
      tick();
      checkOutput("busy_flush_cnt", {16'h0, store_cnt}, 32'd7);
      checkOutput("busy_flush_idle", {31'h0, mem_req}, 32'h0);

      // Counter wrap: bring the count to FFFF, then one more.
      for (int i = 0; i < 65528; i++) begin
         applyStimulus(1'b1, 2'b00, (i % 3072) << 2, $urandom, 1'b0);
         tick();
      end
      applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
      tick();
      checkOutput("cnt_ffff", {16'h0, store_cnt}, 32'h0000_FFFF);
      applyStimulus(1'b1, 2'b01, 32'h0000_0002, 32'h0000_BEEF, 1'b0);
      tick();
      applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
      tick();
      checkOutput("cnt_wrap", {16'h0, store_cnt}, 32'h0);

      // Asynchronous reset while BUSY.
      mem_ack = 1'b0;
      applyStimulus(1'b1, 2'b10, 32'h0000_1001, 32'h0000_0055, 1'b0);
      tick();
      applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
      checkOutput("pre_rst_req", {31'h0, mem_req}, 32'h1);
      resetn = 1'b0;
      sb_q.delete();
      #1;
      checkOutput("arst_req", {31'h0, mem_req}, 32'h0);
      checkOutput("arst_addr", mem_addr, 32'h0);
      checkOutput("arst_wdata", mem_wdata, 32'h0);
      checkOutput("arst_byteen", {28'h0, mem_byteen}, 32'h0);
      checkOutput("arst_cnt", {16'h0, store_cnt}, 32'h0);
      #1;
      resetn  = 1'b1;
      mem_ack = 1'b1;
      tick();
      applyStimulus(1'b1, 2'b10, 32'h0000_1001, 32'h0000_00AB, 1'b0);
      tick();
      checkOutput("post_rst_wdata", mem_wdata, 32'hABAB_ABAB);
      checkOutput("post_rst_be", {28'h0, mem_byteen}, 32'h2);
      checkOutput("post_rst_addr", mem_addr, 32'h0000_1000);
      applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
      tick();
      checkOutput("post_rst_cnt", {16'h0, store_cnt}, 32'd1);
      checkOutput("sb_empty", sb_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/m_store_narrow.md
# m_store_narrow

Memory-stage store unit: the reverse of the immediate/load extenders. It takes a 32-bit register value plus a store width and narrows it to a byte or halfword. It replicates the narrowed value across the word lanes, generates byte enables and detects address-error-on-store. It then holds the request in a one-entry buffer and presents it to data memory with a req/ack handshake, stalling the pipeline when a second store arrives while one is outstanding.

## Interface
- `ADDR_LO`, default 32'h0000_0000: lowest legal store byte address (inclusive).
- `ADDR_HI`, default 32'h0000_2FFF: highest legal store byte address (inclusive).
- `clk`  in  1  pipeline clock; all state on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `store_valid`  in  1  M-stage holds a store instruction this cycle.
- `store_op`  in  2  00 = sw, 01 = sh, 10 = sb, 11 = reserved.
- `store_addr`  in  32  byte address.
- `store_wdata`  in  32  register rt value.
- `flush`  in  1  exception/eret flush of the M-stage instruction.
- `stall`  out  1  combinational; hold the M stage this cycle.
- `exc_ades`  out  1  combinational; address error on store.
- `mem_req`  out  1  registered; request valid.
- `mem_addr`  out  32  registered; word address, {addr[31:2], 2'b00}.
- `mem_wdata`  out  32  registered; lane-replicated data.
- `mem_byteen`  out  4  registered; byte-enable mask.
- `mem_ack`  in  1  memory accepts the request on the edge where `mem_req & mem_ack`.
- `store_cnt`  out  16  registered; number of completed stores, wraps at 16'hFFFF to 0.

## Operation
- Legal store (`legal`): `store_valid`, `store_op != 11`, `!flush`, `!exc_ades`.
- `exc_ades` is 1 when all of the following hold:
  - `store_valid` and `!flush`;
  - the access is misaligned (sh with addr[0] = 1, or sw with addr[1:0] != 0), or `store_addr < ADDR_LO`, or `store_addr > ADDR_HI`.
  - Range check uses the byte address only; width is not added.
- Store op 11 is ignored: not accepted, no exception, no stall.
- A flushed or faulting store is never issued to memory.
- Narrowing rules:
  - sb: wdata = {4{wdata[7:0]}}, byteen = 4'b0001 << addr[1:0].
  - sh: wdata = {2{wdata[15:0]}}, byteen = addr[1] ? 4'b1100 : 4'b0011.
  - sw: wdata unchanged, byteen = 4'b1111.
- State machine, two states:
  - IDLE: `mem_req` = 0. If `legal`, load the buffer, go to BUSY. `stall` = 0.
  - BUSY: `mem_req` = 1, buffer outputs frozen.
    - On `mem_ack`: `store_cnt` += 1. If `legal` in the same cycle, reload the buffer with the new store and stay in BUSY; otherwise go to IDLE.
    - Without `mem_ack`: stay in BUSY.
- `stall` = BUSY & `!mem_ack` & `legal`. A faulting, flushed or reserved-op instruction never stalls.
- `flush` does not cancel the buffered store; it is architecturally committed.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE, `mem_req` 0, `mem_addr` 0, `mem_wdata` 0, `mem_byteen` 0, `store_cnt` 0.
- Reset mid-transaction drops `mem_req` immediately and discards the buffered store.
- Latency: a store accepted at edge N drives `mem_req` with valid data from N+1. It completes at the first edge where `mem_ack` = 1.
- Throughput: with `mem_ack` tied high, one store per cycle; back-to-back stores keep `mem_req` high without a gap.
- Handshake: while `mem_req` = 1 and `mem_ack` = 0, `mem_addr`, `mem_wdata` and `mem_byteen` stay stable. `mem_ack` while `mem_req` = 0 is ignored.
- `stall`, `exc_ades`: same-cycle combinational from inputs and state; no register stage.
- `store_cnt` increments on the completing edge; 16'hFFFF + 1 wraps to 16'h0000.

## Test plan
- Store-width sweep, `mem_ack` tied 1:
  - sb with addr 32'h0000_1003, wdata 32'h1234_5678 -> next cycle `mem_addr` 32'h0000_1000, `mem_wdata` 32'h7878_7878, `mem_byteen` 4'b1000.
  - sh with addr 32'h0000_1002 -> `mem_wdata` 32'h5678_5678, `mem_byteen` 4'b1100.
  - sw with addr 32'h0000_1000 -> `mem_wdata` 32'h1234_5678, `mem_byteen` 4'b1111.
- Address errors -> `exc_ades` = 1 same cycle, `mem_req` stays 0, `stall` = 0:
  - sw at addr 32'h0000_1002;
  - sh at addr 32'h0000_0001;
  - sb at addr 32'h0000_3000.
- Slow memory: store A accepted, `mem_ack` held 0 for 3 cycles, store B presented.
  - Required: `stall` = 1 for those 3 cycles, A outputs stable.
  - Ack edge: B loaded with no gap in `mem_req`, `store_cnt` = 1.
- Flush and reserved op: sw with `flush` = 1, and op 11 -> neither issued, no stall, no exception. A flush during BUSY still completes the buffered store.
- Counter wrap: preload via 65535 acknowledged stores, one more -> `store_cnt` = 0.
- Reset mid-BUSY: drive `resetn` = 0 asynchronously -> `mem_req` falls before the next edge, all outputs 0. After release, a new sb issues normally.
